// File: rtl/mbp_ghr_ckpt_pkg.sv
// -----------------------------------------------------------------------------
// mbp_pkg
// Shared types and default sizes for the speculative global-history block.
//   MBP_HIST_LEN : default history length in bits (LSB = newest outcome)
//   MBP_NR_CKPT  : default number of checkpoint entries (power of two, >= 2)
//   ghr_t        : history word at the default length
//   ckpt_idx_t   : checkpoint tag at the default entry count
// -----------------------------------------------------------------------------
package mbp_pkg;

    localparam int MBP_HIST_LEN = 8;
    localparam int MBP_NR_CKPT  = 8;
    localparam int MBP_CKPT_W   = $clog2(MBP_NR_CKPT);

    typedef logic [MBP_HIST_LEN-1:0] ghr_t;
    typedef logic [MBP_CKPT_W-1:0]   ckpt_idx_t;

endpackage

// File: rtl/mbp_ghr_ckpt_if.sv
// -----------------------------------------------------------------------------
// mbp_ghr_ckpt_if
// Prediction and resolution handshake between the frontend/execute side and
// the history checkpoint block.
//   pred_valid_i / pred_taken_i        : one predicted conditional branch
//   pred_ready_o / pred_ckpt_o         : checkpoint free / tag for the branch
//   res_valid_i / res_ckpt_i           : oldest branch resolves / its tag
//   res_taken_i / res_mispredict_i     : actual direction / mispredict flag
// Modports: master drives the requests, slave is the history block.
// -----------------------------------------------------------------------------
interface mbp_ghr_ckpt_if
    import mbp_pkg::*;
#(
    parameter int NR_CKPT = MBP_NR_CKPT
);
    localparam int CKPT_W = $clog2(NR_CKPT);

    logic              pred_valid_i;
    logic              pred_taken_i;
    logic              pred_ready_o;
    logic [CKPT_W-1:0] pred_ckpt_o;
    logic              res_valid_i;
    logic [CKPT_W-1:0] res_ckpt_i;
    logic              res_taken_i;
    logic              res_mispredict_i;

    modport master (
        output pred_valid_i, pred_taken_i,
        output res_valid_i, res_ckpt_i, res_taken_i, res_mispredict_i,
        input  pred_ready_o, pred_ckpt_o
    );

    modport slave (
        input  pred_valid_i, pred_taken_i,
        input  res_valid_i, res_ckpt_i, res_taken_i, res_mispredict_i,
        output pred_ready_o, pred_ckpt_o
    );

endinterface

// File: rtl/mbp_ghr_ckpt_buf.sv
// -----------------------------------------------------------------------------
// mbp_ghr_ckpt_buf
// Circular checkpoint storage: one history snapshot per unresolved branch.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all entries (head jumps to tail, count to 0)
//   push       : write push_data at tail, advance tail
//   pop        : retire the entry at head, advance head
//   head_data  : snapshot stored at head
//   head, tail : pointers (tail is the tag handed to the next push)
//   count      : live entries, 0..NR_CKPT
// clear overrides push/pop; push and pop together leave count unchanged.
// -----------------------------------------------------------------------------
module mbp_ghr_ckpt_buf
    import mbp_pkg::*;
#(
    parameter int HIST_LEN = MBP_HIST_LEN,
    parameter int NR_CKPT  = MBP_NR_CKPT,
    localparam int IDX_W   = $clog2(NR_CKPT),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  logic [HIST_LEN-1:0] push_data,
    input  logic                pop,
    output logic [HIST_LEN-1:0] head_data,
    output logic [IDX_W-1:0]    head,
    output logic [IDX_W-1:0]    tail,
    output logic [CNT_W-1:0]    count
);

    logic [HIST_LEN-1:0] mem [NR_CKPT];

    // Snapshot storage needs no reset: an entry is only read after it is pushed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_data;
        end
    end

    // NR_CKPT is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + IDX_W'(1);
            end
            if (pop) begin
                head <= head + IDX_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/mbp_ghr_ckpt.sv
// -----------------------------------------------------------------------------
// mbp_ghr_ckpt
// Speculative global-history register with per-branch checkpoints. Predicted
// directions shift into ghr_o and each accepted prediction snapshots the prior
// history; in-order resolutions shift the real outcome into ghr_commit_o, and
// a mispredict rebuilds both from the resolving branch's snapshot.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : drop all checkpoints, ghr_o takes the committed history
//   bus (slave)   : prediction / resolution handshake (mbp_ghr_ckpt_if)
//   ghr_o         : speculative history (registered)
//   ghr_commit_o  : committed history (registered)
//   count_o       : live checkpoints
//   err_o         : sticky tag-order error
// Build option MBP_GHR_CHECK_EN: enables err_o (resolve with no live branch,
// or res_ckpt_i not equal to head). Without it res_ckpt_i is ignored and
// err_o is tied low.
// -----------------------------------------------------------------------------
module mbp_ghr_ckpt
    import mbp_pkg::*;
#(
    parameter int HIST_LEN = MBP_HIST_LEN,
    parameter int NR_CKPT  = MBP_NR_CKPT,
    localparam int IDX_W   = $clog2(NR_CKPT),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    mbp_ghr_ckpt_if.slave       bus,
    output logic [HIST_LEN-1:0] ghr_o,
    output logic [HIST_LEN-1:0] ghr_commit_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NR_CKPT);

    function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                      input logic bit_in);
        return {h[HIST_LEN-2:0], bit_in};
    endfunction

    logic                accept;
    logic                res_live;
    logic                res_correct;
    logic                res_mispredict;
    logic                buf_clear;
    logic [HIST_LEN-1:0] head_data;
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;
    logic [HIST_LEN-1:0] ghr_nxt;
    logic [HIST_LEN-1:0] commit_nxt;

    // A resolve with nothing outstanding is illegal and must not touch state.
    assign res_live       = bus.res_valid_i && (count_o != '0);
    assign res_correct    = res_live && !bus.res_mispredict_i;
    assign res_mispredict = res_live && bus.res_mispredict_i;

    assign accept = bus.pred_valid_i && bus.pred_ready_o && !flush_i
                    && !(bus.res_valid_i && bus.res_mispredict_i);

    assign buf_clear = flush_i || res_mispredict;

    assign bus.pred_ready_o = (count_o != FULL);
    assign bus.pred_ckpt_o  = tail;

    mbp_ghr_ckpt_buf #(
        .HIST_LEN (HIST_LEN),
        .NR_CKPT  (NR_CKPT)
    ) u_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (buf_clear),
        .push      (accept),
        .push_data (ghr_o),
        .pop       (res_correct),
        .head_data (head_data),
        .head      (head),
        .tail      (tail),
        .count     (count_o)
    );

    always_comb begin
        commit_nxt = ghr_commit_o;
        if (res_mispredict) begin
            commit_nxt = shift_in(head_data, bus.res_taken_i);
        end else if (res_correct) begin
            commit_nxt = shift_in(ghr_commit_o, bus.res_taken_i);
        end
    end

    // Flush sees the committed history including this cycle's resolve.
    always_comb begin
        ghr_nxt = ghr_o;
        if (flush_i) begin
            ghr_nxt = commit_nxt;
        end else if (res_mispredict) begin
            ghr_nxt = shift_in(head_data, bus.res_taken_i);
        end else if (accept) begin
            ghr_nxt = shift_in(ghr_o, bus.pred_taken_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_o        <= '0;
            ghr_commit_o <= '0;
        end else begin
            ghr_o        <= ghr_nxt;
            ghr_commit_o <= commit_nxt;
        end
    end

`ifdef MBP_GHR_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (bus.res_valid_i && ((count_o == '0) || (bus.res_ckpt_i != head))) begin
            err_o <= 1'b1;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{bus.res_ckpt_i, head};
    assign err_o      = 1'b0;
`endif

endmodule

// File: doc/mbp_ghr_ckpt.md
# mbp_ghr_ckpt

Speculative global-history register (GHR) with per-branch checkpoints, sitting directly upstream of the multiple branch predictor's global component. It supplies the history used to index the global predictor, shifts in each predicted conditional-branch direction speculatively, and takes a checkpoint per prediction. When a branch resolves in order from execute, it commits the real outcome to an architectural history copy. On a mispredict it restores the speculative history from that branch's checkpoint.

## Interface
Parameters:
- HIST_LEN, 8: history length in bits; LSB is the newest outcome.
- NR_CKPT, 8: checkpoint entries, i.e. maximum unresolved conditional branches; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush: drop all checkpoints; speculative history takes the committed value.
- pred_valid_i  in  1  frontend predicts one conditional branch this cycle.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  checkpoint free (count_o != NR_CKPT).
- pred_ckpt_o  out  $clog2(NR_CKPT)  tag given to the branch accepted this cycle (tail pointer).
- res_valid_i  in  1  oldest unresolved branch resolves this cycle.
- res_ckpt_i  in  $clog2(NR_CKPT)  tag of the resolving branch.
- res_taken_i  in  1  actual direction.
- res_mispredict_i  in  1  direction mispredicted; qualified by res_valid_i.
- ghr_o  out  HIST_LEN  speculative history, registered.
- ghr_commit_o  out  HIST_LEN  committed history, registered.
- count_o  out  $clog2(NR_CKPT)+1  live checkpoints.
- err_o  out  1  sticky tag-order error; present only with the configuration macro.

## Operation
- **Shift rule:** next = {h[HIST_LEN-2:0], bit}.
- **Accept:** a prediction is accepted when pred_valid_i && pred_ready_o && !flush_i && !(res_valid_i && res_mispredict_i). On accept:
  - ckpt[tail] = ghr_o (history before this branch).
  - ghr_o shifts in pred_taken_i.
  - tail increments modulo NR_CKPT.
  - A non-accepted pred_valid_i has no effect.
- **Resolve, correct** (res_valid_i, !res_mispredict_i):
  - ghr_commit_o shifts in res_taken_i.
  - head increments modulo NR_CKPT.
  - ghr_o is untouched apart from any same-cycle accept.
- **Resolve, mispredict:**
  - ghr_o = shift(ckpt[head], res_taken_i).
  - ghr_commit_o takes the same value.
  - All checkpoints are freed: head = tail, count 0.
  - A same-cycle prediction is discarded.
- Resolution is strictly in order, so ckpt[head] always equals ghr_commit_o.
- res_valid_i with count_o == 0 is illegal. Nothing is updated, and err_o sets when the macro is enabled.
- **Flush** has priority over prediction:
  - ghr_o = ghr_commit_o after any same-cycle resolve update.
  - count 0, head = tail.
- **count_o:** +1 on accept, −1 on correct resolve, both in the same cycle leave it unchanged, 0 on mispredict, flush or reset.
- **Full:** count_o == NR_CKPT drops pred_ready_o. A same-cycle correct resolve does not raise pred_ready_o combinationally; it rises the next cycle.

## Timing
- Reset values: ghr_o = 0, ghr_commit_o = 0, count_o = 0, pred_ready_o = 1, pred_ckpt_o = 0, err_o = 0; head = tail = 0.
- Reset mid-operation discards everything in one cycle.
- Latency: every update is visible on ghr_o, ghr_commit_o and count_o one cycle after the triggering edge.
- pred_ready_o and pred_ckpt_o depend on registered state only; there is no combinational path from any input to any output.
- Throughput: one prediction and one resolve per cycle.

## Configuration
- MBP_GHR_CHECK_EN defined:
  - err_o sets and stays set (until rst_i) on res_valid_i with count_o == 0.
  - err_o sets and stays set on res_valid_i with res_ckpt_i != head.
  - State updates proceed as if the tag matched.
- MBP_GHR_CHECK_EN undefined: res_ckpt_i is ignored and err_o is tied to 0.

## Structure
- Shared package mbp_pkg holds:
  - typedef ghr_t (logic [HIST_LEN-1:0]).
  - typedef ckpt_idx_t.
  - constants MBP_HIST_LEN and MBP_NR_CKPT, used as the defaults.
- One sub-module, mbp_ghr_ckpt_buf: circular checkpoint storage with head/tail pointers, count, push, pop and clear.
- The top level holds both history registers and the priority logic.

## Test plan
1. **Reset:** assert rst_i for 2 cycles → ghr_o = 0x00, ghr_commit_o = 0x00, count_o = 0, pred_ready_o = 1, pred_ckpt_o = 0, err_o = 0.
2. **Predict:** predict T, T, N on consecutive cycles → pred_ckpt_o = 0, 1, 2; final ghr_o = 0x06, count_o = 3.
3. **Correct then mispredict:** from scenario 2, resolve tag 0 taken correctly → ghr_commit_o = 0x01, count_o = 2, ghr_o = 0x06. Then resolve tag 1 mispredicted with actual N → ghr_o = 0x02, ghr_commit_o = 0x02, count_o = 0.
4. **Full and wrap:** 8 predictions without resolve → count_o = 8, pred_ready_o = 0; a 9th pred_valid_i leaves ghr_o unchanged. Resolve one correctly → pred_ready_o = 1 the next cycle, and the next accepted tag is 0 (wrap).
5. **Flush:** with count_o = 3 and ghr_commit_o = 0x01, a flush_i cycle with a simultaneous pred_valid_i → ghr_o = 0x01, count_o = 0, no checkpoint allocated.
6. **Tag error (MBP_GHR_CHECK_EN):** res_valid_i with res_ckpt_i = 3 while head = 0 → err_o = 1 the next cycle and held until rst_i. Repeat with the macro undefined → err_o stays 0.
